// File: rtl/im_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package im_loader_pkg;

  typedef enum logic [2:0] {
    HDR_HI = 3'd0,
    HDR_LO = 3'd1,
    DATA   = 3'd2,
    WRITE  = 3'd3,
    CSUM   = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } state_t;

  localparam logic IM_WR      = 1'b1;
  localparam int   HDR_BYTES  = 2;
  localparam int   WORD_BYTES = 4;

endpackage

// File: rtl/im_loader_word_asm.sv
// Big-endian word assembler: shifts stream bytes in MSB first and flags the
// byte that completes a word, presenting the full word in that same cycle.
module im_word_asm
  import im_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clear,
  input  logic        i_shift,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_valid
);

  logic [23:0] r_shift;
  logic [1:0]  r_cnt;

  // The completing byte is folded in combinationally so the writer can latch
  // the whole word on the very edge that accepts its last byte.
  assign o_word       = {r_shift, i_byte};
  assign o_word_valid = i_shift && (r_cnt == 2'(WORD_BYTES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_clear) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_shift) begin
      r_shift <= o_word[23:0];
      r_cnt   <= r_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/im_loader.sv
// Streams a length-prefixed big-endian image into instruction memory and holds
// the CPU in reset until done. Optional checksum byte: define IM_LOADER_CSUM_EN.
module im_loader
  import im_loader_pkg::*;
#(
  parameter int          MAX_WORDS = 20,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  i_in_byte,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic        i_reload,
  output logic [31:0] o_im_add,
  output logic [31:0] o_im_data,
  output logic        o_im_en,
  output logic        o_im_rd_wr,
  output logic        o_cpu_rst,
  output logic        o_load_done,
  output logic        o_load_err
);

`ifdef IM_LOADER_CSUM_EN
  localparam state_t END_STATE = CSUM;
  logic [7:0] r_xor;
`else
  localparam state_t END_STATE = DONE;
`endif

  state_t      r_state;
  logic [15:0] r_n;
  logic [15:0] r_idx;
  logic [31:0] r_im_add;
  logic [31:0] r_im_data;
  logic        r_im_en;
  logic        r_im_rd_wr;
  logic        r_cpu_rst;
  logic        r_load_done;
  logic        r_load_err;

  logic        w_xfer;
  logic        w_shift;
  logic [15:0] w_n_full;
  logic [15:0] w_idx_next;
  logic [31:0] w_word;
  logic        w_word_valid;

  // Gated by rst_n so no byte is ever accepted while reset is asserted.
  assign o_in_ready = rst_n && ((r_state == HDR_HI) || (r_state == HDR_LO) ||
                                (r_state == DATA)   || (r_state == CSUM));
  assign w_xfer     = i_in_valid && o_in_ready;
  assign w_shift    = w_xfer && (r_state == DATA) && !i_reload;
  assign w_n_full   = {r_n[15:8], i_in_byte};
  assign w_idx_next = r_idx + 16'd1;

  im_word_asm u_word_asm (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clear      (i_reload),
    .i_shift      (w_shift),
    .i_byte       (i_in_byte),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= HDR_HI;
      r_n         <= '0;
      r_idx       <= '0;
      r_im_add    <= BASE_ADDR;
      r_im_data   <= '0;
      r_im_en     <= 1'b0;
      r_im_rd_wr  <= 1'b0;
      r_cpu_rst   <= 1'b0;
      r_load_done <= 1'b0;
      r_load_err  <= 1'b0;
`ifdef IM_LOADER_CSUM_EN
      r_xor       <= '0;
`endif
    end else if (i_reload) begin
      r_state     <= HDR_HI;
      r_n         <= '0;
      r_idx       <= '0;
      r_im_en     <= 1'b0;
      r_im_rd_wr  <= 1'b0;
      r_cpu_rst   <= 1'b0;
      r_load_done <= 1'b0;
      r_load_err  <= 1'b0;
`ifdef IM_LOADER_CSUM_EN
      r_xor       <= '0;
`endif
    end else begin
      r_im_en    <= 1'b0;
      r_im_rd_wr <= 1'b0;
`ifdef IM_LOADER_CSUM_EN
      if (w_xfer && ((r_state == HDR_HI) || (r_state == HDR_LO) || (r_state == DATA)))
        r_xor <= r_xor ^ i_in_byte;
`endif
      case (r_state)
        HDR_HI: begin
          if (w_xfer) begin
            r_n     <= {i_in_byte, 8'h00};
            r_state <= HDR_LO;
          end
        end
        HDR_LO: begin
          if (w_xfer) begin
            r_n[7:0] <= i_in_byte;
            if (w_n_full > 16'(MAX_WORDS)) begin
              r_state    <= ERR;
              r_load_err <= 1'b1;
            end else if (w_n_full == 16'd0) begin
              r_state     <= END_STATE;
              r_load_done <= (END_STATE == DONE);
            end else begin
              r_state <= DATA;
            end
          end
        end
        DATA: begin
          if (w_word_valid) begin
            r_state    <= WRITE;
            r_im_en    <= 1'b1;
            r_im_rd_wr <= IM_WR;
            r_im_add   <= BASE_ADDR + {14'b0, r_idx, 2'b00};
            r_im_data  <= w_word;
          end
        end
        WRITE: begin
          r_idx <= w_idx_next;
          if (w_idx_next == r_n) begin
            r_state     <= END_STATE;
            r_load_done <= (END_STATE == DONE);
          end else begin
            r_state <= DATA;
          end
        end
        CSUM: begin
`ifdef IM_LOADER_CSUM_EN
          if (w_xfer) begin
            if (i_in_byte == r_xor) begin
              r_state     <= DONE;
              r_load_done <= 1'b1;
            end else begin
              r_state    <= ERR;
              r_load_err <= 1'b1;
            end
          end
`else
          r_state    <= ERR;
          r_load_err <= 1'b1;
`endif
        end
        DONE: begin
          r_cpu_rst <= 1'b1;
        end
        ERR: begin
          r_load_err <= 1'b1;
        end
        default: begin
          r_state    <= ERR;
          r_load_err <= 1'b1;
        end
      endcase
    end
  end

  assign o_im_add    = r_im_add;
  assign o_im_data   = r_im_data;
  assign o_im_en     = r_im_en;
  assign o_im_rd_wr  = r_im_rd_wr;
  assign o_cpu_rst   = r_cpu_rst;
  assign o_load_done = r_load_done;
  assign o_load_err  = r_load_err;

endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader: header/data streaming, oversize header, empty
// image, in_valid gaps, reload mid-word and asynchronous reset mid-write.
module tb_im_loader;

  logic        clk;
  logic        rstN;
  logic [7:0]  inByte;
  logic        inValid;
  logic        inReady;
  logic        reload;
  logic [31:0] imAdd;
  logic [31:0] imData;
  logic        imEn;
  logic        imRdWr;
  logic        cpuRst;
  logic        loadDone;
  logic        loadErr;

  int          assertCount;
  int          failCount;
  int          wrCount;
  int          writeBad;
  int          startIdx;
  int          badStart;
  logic [31:0] wrAddr [32];
  logic [31:0] wrData [32];
  logic [7:0]  runningXor;

  im_loader dut (
    .clk         (clk),
    .rst_n       (rstN),
    .i_in_byte   (inByte),
    .i_in_valid  (inValid),
    .o_in_ready  (inReady),
    .i_reload    (reload),
    .o_im_add    (imAdd),
    .o_im_data   (imData),
    .o_im_en     (imEn),
    .o_im_rd_wr  (imRdWr),
    .o_cpu_rst   (cpuRst),
    .o_load_done (loadDone),
    .o_load_err  (loadErr)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Logs every write strobe and flags any write cycle with in_ready high or
  // im_rd_wr low.
  always @(negedge clk) begin
    if (imEn === 1'b1) begin
      if (wrCount < 32) begin
        wrAddr[wrCount] = imAdd;
        wrData[wrCount] = imData;
      end
      wrCount = wrCount + 1;
      if (inReady !== 1'b0 || imRdWr !== 1'b1) writeBad = writeBad + 1;
    end
  end

  // One comparison: counts it and reports tag/observed/expected on failure.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Offers one byte after 'gap' idle cycles, holds it until accepted, and
  // returns at the falling edge after the accepting rising edge.
  task automatic applyStimulus(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    inByte  = b;
    inValid = 1'b1;
    n = 0;
    while (inReady !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("inReadyWait", {31'b0, inReady}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    inValid    = 1'b0;
    runningXor = runningXor ^ b;
  endtask

  // Ends an image: the checksum byte when that feature is built, otherwise
  // just the one WRITE-to-DONE cycle.
  task automatic finishImage();
`ifdef IM_LOADER_CSUM_EN
    logic [7:0] c;
    c = runningXor;
    applyStimulus(c, 0);
`else
    @(negedge clk);
`endif
  endtask

  // One-cycle reload pulse, issued from a falling edge.
  task automatic pulseReload();
    reload = 1'b1;
    @(negedge clk);
    reload     = 1'b0;
    runningXor = 8'h00;
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    wrCount     = 0;
    writeBad    = 0;
    runningXor  = 8'h00;
    rstN        = 1'b0;
    inByte      = 8'h00;
    inValid     = 1'b0;
    reload      = 1'b0;

    // Reset values while rst_n is held low.
    @(negedge clk);
    @(negedge clk);
    checkOutput("rstInReady",  {31'b0, inReady},  32'd0);
    checkOutput("rstImAdd",    imAdd,             32'h0);
    checkOutput("rstImData",   imData,            32'h0);
    checkOutput("rstImEn",     {31'b0, imEn},     32'd0);
    checkOutput("rstImRdWr",   {31'b0, imRdWr},   32'd0);
    checkOutput("rstCpuRst",   {31'b0, cpuRst},   32'd0);
    checkOutput("rstLoadDone", {31'b0, loadDone}, 32'd0);
    checkOutput("rstLoadErr",  {31'b0, loadErr},  32'd0);
    rstN = 1'b1;
    #1;
    checkOutput("hdrHiReady", {31'b0, inReady}, 32'd1);

    // Two-word image 00 02 | 24010005 | 20020007.
    startIdx = wrCount;
    applyStimulus(8'h00, 0);
    applyStimulus(8'h02, 0);
    applyStimulus(8'h24, 0);
    applyStimulus(8'h01, 0);
    applyStimulus(8'h00, 0);
    applyStimulus(8'h05, 0);
    checkOutput("w0En",   {31'b0, imEn},   32'd1);
    checkOutput("w0RdWr", {31'b0, imRdWr}, 32'd1);
    checkOutput("w0Add",  imAdd,           32'h0);
    checkOutput("w0Data", imData,          32'h24010005);
    checkOutput("w0InReady", {31'b0, inReady}, 32'd0);
    checkOutput("w0NotDone", {31'b0, loadDone}, 32'd0);
    applyStimulus(8'h20, 0);
    applyStimulus(8'h02, 0);
    applyStimulus(8'h00, 0);
    applyStimulus(8'h07, 0);
    checkOutput("w1En",   {31'b0, imEn}, 32'd1);
    checkOutput("w1Add",  imAdd,         32'h4);
    checkOutput("w1Data", imData,        32'h20020007);
    finishImage();
    checkOutput("aDone",     {31'b0, loadDone}, 32'd1);
    checkOutput("aCpuRst0",  {31'b0, cpuRst},   32'd0);
    checkOutput("aEnLow",    {31'b0, imEn},     32'd0);
    checkOutput("aRdWrLow",  {31'b0, imRdWr},   32'd0);
    checkOutput("aAddHold",  imAdd,             32'h4);
    checkOutput("aDataHold", imData,            32'h20020007);
    checkOutput("aReadyLow", {31'b0, inReady},  32'd0);
    @(negedge clk);
    checkOutput("aCpuRst1",  {31'b0, cpuRst},   32'd1);
    checkOutput("aWrites",   wrCount - startIdx, 32'd2);

    // Oversized header 00 15 (21 words) must abort with no writes.
    pulseReload();
    checkOutput("rlDoneClr",  {31'b0, loadDone}, 32'd0);
    checkOutput("rlCpuRst",   {31'b0, cpuRst},   32'd0);
    checkOutput("rlReady",    {31'b0, inReady},  32'd1);
    startIdx = wrCount;
    applyStimulus(8'h00, 0);
    applyStimulus(8'h15, 0);
    checkOutput("bigErr",   {31'b0, loadErr},  32'd1);
    checkOutput("bigReady", {31'b0, inReady},  32'd0);
    repeat (3) @(negedge clk);
    checkOutput("bigCpuRst", {31'b0, cpuRst},   32'd0);
    checkOutput("bigNoDone", {31'b0, loadDone}, 32'd0);
    checkOutput("bigWrites", wrCount - startIdx, 32'd0);

    // Empty image 00 00.
    pulseReload();
    checkOutput("rlErrClr", {31'b0, loadErr}, 32'd0);
    startIdx = wrCount;
    applyStimulus(8'h00, 0);
    applyStimulus(8'h00, 0);
`ifdef IM_LOADER_CSUM_EN
    checkOutput("emptyCsumReady", {31'b0, inReady}, 32'd1);
    applyStimulus(8'h00, 0);
`endif
    checkOutput("emptyDone", {31'b0, loadDone}, 32'd1);
    @(negedge clk);
    checkOutput("emptyCpuRst", {31'b0, cpuRst}, 32'd1);
    checkOutput("emptyWrites", wrCount - startIdx, 32'd0);
`ifdef IM_LOADER_CSUM_EN
    pulseReload();
    applyStimulus(8'h00, 0);
    applyStimulus(8'h00, 0);
    applyStimulus(8'h01, 0);
    checkOutput("csumBadErr",  {31'b0, loadErr},  32'd1);
    checkOutput("csumBadDone", {31'b0, loadDone}, 32'd0);
`endif

    // Three-word image with random idle gaps between bytes.
    pulseReload();
    startIdx = wrCount;
    badStart = writeBad;
    applyStimulus(8'h00, $urandom_range(0, 3));
    applyStimulus(8'h03, $urandom_range(0, 3));
    applyStimulus(8'h11, $urandom_range(0, 3));
    applyStimulus(8'h22, $urandom_range(0, 3));
    applyStimulus(8'h33, $urandom_range(0, 3));
    applyStimulus(8'h44, $urandom_range(0, 3));
    applyStimulus(8'h55, $urandom_range(0, 3));
    applyStimulus(8'h66, $urandom_range(0, 3));
    applyStimulus(8'h77, $urandom_range(0, 3));
    applyStimulus(8'h88, $urandom_range(0, 3));
    applyStimulus(8'h99, $urandom_range(0, 3));
    applyStimulus(8'hAA, $urandom_range(0, 3));
    applyStimulus(8'hBB, $urandom_range(0, 3));
    applyStimulus(8'hCC, $urandom_range(0, 3));
    finishImage();
    checkOutput("gapDone",   {31'b0, loadDone}, 32'd1);
    @(negedge clk);
    checkOutput("gapWrites", wrCount - startIdx, 32'd3);
    checkOutput("gapAdd0",   wrAddr[startIdx],     32'h0);
    checkOutput("gapAdd1",   wrAddr[startIdx + 1], 32'h4);
    checkOutput("gapAdd2",   wrAddr[startIdx + 2], 32'h8);
    checkOutput("gapData0",  wrData[startIdx],     32'h11223344);
    checkOutput("gapData1",  wrData[startIdx + 1], 32'h55667788);
    checkOutput("gapData2",  wrData[startIdx + 2], 32'h99AABBCC);
    checkOutput("gapWriteReady", writeBad - badStart, 32'd0);

    // Reload after two bytes of word 0 drops the partial word.
    pulseReload();
    startIdx = wrCount;
    applyStimulus(8'h00, 0);
    applyStimulus(8'h01, 0);
    applyStimulus(8'h11, 0);
    applyStimulus(8'h22, 0);
    pulseReload();
    applyStimulus(8'h00, 0);
    applyStimulus(8'h01, 0);
    applyStimulus(8'hAA, 0);
    applyStimulus(8'hBB, 0);
    applyStimulus(8'hCC, 0);
    applyStimulus(8'hDD, 0);
    finishImage();
    checkOutput("rlpDone",   {31'b0, loadDone}, 32'd1);
    @(negedge clk);
    checkOutput("rlpWrites", wrCount - startIdx, 32'd1);
    checkOutput("rlpAdd",    wrAddr[startIdx],   32'h0);
    checkOutput("rlpData",   wrData[startIdx],   32'hAABBCCDD);

    // Asynchronous reset in the middle of a WRITE cycle.
    pulseReload();
    applyStimulus(8'h00, 0);
    applyStimulus(8'h01, 0);
    applyStimulus(8'hDE, 0);
    applyStimulus(8'hAD, 0);
    applyStimulus(8'hBE, 0);
    applyStimulus(8'hEF, 0);
    checkOutput("preRstEn", {31'b0, imEn}, 32'd1);
    #1;
    rstN = 1'b0;
    #1;
    checkOutput("midRstEn",     {31'b0, imEn},    32'd0);
    checkOutput("midRstCpuRst", {31'b0, cpuRst},  32'd0);
    checkOutput("midRstReady",  {31'b0, inReady}, 32'd0);
    checkOutput("midRstAdd",    imAdd,            32'h0);
    checkOutput("midRstData",   imData,           32'h0);
    @(negedge clk);
    rstN       = 1'b1;
    runningXor = 8'h00;
    #1;
    checkOutput("postRstReady", {31'b0, inReady}, 32'd1);
    startIdx = wrCount;
    applyStimulus(8'h00, 0);
    applyStimulus(8'h01, 0);
    applyStimulus(8'h01, 0);
    applyStimulus(8'h02, 0);
    applyStimulus(8'h03, 0);
    applyStimulus(8'h04, 0);
    finishImage();
    checkOutput("postRstDone", {31'b0, loadDone}, 32'd1);
    @(negedge clk);
    checkOutput("postRstWrites", wrCount - startIdx, 32'd1);
    checkOutput("postRstAdd",    wrAddr[startIdx],   32'h0);
    checkOutput("postRstData",   wrData[startIdx],   32'h01020304);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
